// File: rtl/execute_pkg.sv
// Shared widths and record types for the execute issue stage slice.
package execute_pkg;

   localparam int DATA_W = 16;
   localparam int CTRL_W = 6;
   localparam int NREGS  = 8;
   localparam int RIDX_W = $clog2(NREGS);

   typedef logic [RIDX_W-1:0] ridx_t;

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      ridx_t             dr;
      ridx_t             sr1;
      ridx_t             sr2;
      logic [DATA_W-1:0] imm;
      logic              wb;
   } issue_instr_t;

   typedef struct packed {
      logic  valid;
      ridx_t dr;
      logic  wb;
   } ex_tag_t;

   function automatic logic readsReg(input ridx_t sr1, input ridx_t sr2, input ridx_t r);
      return (sr1 == r) || (sr2 == r);
   endfunction

endpackage

// File: rtl/execute_issue_stage_if.sv
// Decoded-instruction handshake from the decoder into the issue stage.
interface execute_issue_if;
   import execute_pkg::*;

   logic              instr_valid;
   logic              instr_ready;
   logic [CTRL_W-1:0] instr_ctrl;
   ridx_t             instr_dr;
   ridx_t             instr_sr1;
   ridx_t             instr_sr2;
   logic [DATA_W-1:0] instr_imm;
   logic              instr_wb;

   modport master (
      output instr_valid, instr_ctrl, instr_dr, instr_sr1, instr_sr2, instr_imm, instr_wb,
      input  instr_ready
   );

   modport slave (
      input  instr_valid, instr_ctrl, instr_dr, instr_sr1, instr_sr2, instr_imm, instr_wb,
      output instr_ready
   );

endinterface

// File: rtl/issue_regfile.sv
// Architectural register file: two combinational read ports that see the
// value being written this cycle, one write port, async clear.
module issue_regfile
   import execute_pkg::*;
(
   input  logic                   clock,
   input  logic                   reset,
   input  ridx_t [1:0]            rdAddr,
   output logic  [1:0][DATA_W-1:0] rdData,
   input  logic                   wrEn,
   input  ridx_t                  wrAddr,
   input  logic  [DATA_W-1:0]     wrData
);

   logic [DATA_W-1:0] regs [NREGS];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wrEn) begin
         regs[wrAddr] <= wrData;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gRead
         // Bypass lets an instruction issued alongside a writeback see the new value.
         assign rdData[gi] = (wrEn && (wrAddr == rdAddr[gi])) ? wrData : regs[rdAddr[gi]];
      end
   endgenerate

endmodule

// File: rtl/execute_issue_stage.sv
// Issue stage in front of Execute: reads operands, tracks the EX/WB tags,
// writes results back and stalls one cycle on a RAW hazard against EX.
module execute_issue_stage
   import execute_pkg::*;
(
   input  logic                clock,
   input  logic                reset,
   execute_issue_if.slave      instr,
   output logic [DATA_W-1:0]   src1,
   output logic [DATA_W-1:0]   src2,
   output logic [DATA_W-1:0]   imm,
   output logic [CTRL_W-1:0]   control_in,
   output logic                enable_ex,
   input  logic [DATA_W-1:0]   aluout,
   output logic                wb_valid
);

   issue_instr_t             cur;
   ex_tag_t                  exTagReg;
   ex_tag_t                  exTagNext;
   ex_tag_t                  wbTagReg;
   logic                     hazard;
   logic                     accept;
   ridx_t [1:0]              rdAddr;
   logic  [1:0][DATA_W-1:0]  rdData;

   assign cur = '{ctrl: instr.instr_ctrl, dr: instr.instr_dr, sr1: instr.instr_sr1,
                  sr2: instr.instr_sr2, imm: instr.instr_imm, wb: instr.instr_wb};

   // Only the producer in EX can conflict; one cycle later it sits in WB and the bypass covers it.
   assign hazard            = exTagReg.valid && exTagReg.wb && readsReg(cur.sr1, cur.sr2, exTagReg.dr);
   assign instr.instr_ready = !hazard;
   assign accept            = instr.instr_valid && !hazard;

   assign enable_ex = exTagReg.valid;
   assign wb_valid  = wbTagReg.valid && wbTagReg.wb;
   assign rdAddr    = {cur.sr2, cur.sr1};

   always_comb begin
      exTagNext       = '0;
      exTagNext.valid = accept;
      exTagNext.dr    = cur.dr;
      exTagNext.wb    = cur.wb;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         exTagReg   <= '0;
         wbTagReg   <= '0;
         src1       <= '0;
         src2       <= '0;
         imm        <= '0;
         control_in <= '0;
      end else begin
         exTagReg <= exTagNext;
         wbTagReg <= exTagReg;
         if (accept) begin
            src1       <= rdData[0];
            src2       <= rdData[1];
            imm        <= cur.imm;
            control_in <= cur.ctrl;
         end
      end
   end

   issue_regfile uRegfile (
      .clock  (clock),
      .reset  (reset),
      .rdAddr (rdAddr),
      .rdData (rdData),
      .wrEn   (wb_valid),
      .wrAddr (wbTagReg.dr),
      .wrData (aluout)
   );

endmodule

// File: tb/tb_execute_issue_stage.sv
// Directed table-driven bench for execute_issue_stage with a simple
// Execute model (aluout = src1 + src2 + imm, one cycle after enable_ex).
module tb_execute_issue_stage;
   import execute_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   execute_issue_if bus ();

   logic [DATA_W-1:0] src1, src2, imm, aluout;
   logic [CTRL_W-1:0] control_in;
   logic              enable_ex, wb_valid;

   execute_issue_stage dut (
      .clock      (clock),
      .reset      (reset),
      .instr      (bus),
      .src1       (src1),
      .src2       (src2),
      .imm        (imm),
      .control_in (control_in),
      .enable_ex  (enable_ex),
      .aluout     (aluout),
      .wb_valid   (wb_valid)
   );

   always @(posedge clock or negedge reset) begin
      if (!reset) aluout <= '0;
      else if (enable_ex) aluout <= src1 + src2 + imm;
   end

   typedef struct packed {
      logic        valid;
      logic [5:0]  ctrl;
      logic [2:0]  dr;
      logic [2:0]  sr1;
      logic [2:0]  sr2;
      logic [15:0] immIn;
      logic        wb;
      logic        eReady;
      logic        eWbv;
      logic        eEn;
      logic [15:0] eSrc1;
      logic [15:0] eSrc2;
      logic [15:0] eImm;
      logic [5:0]  eCtrl;
   } vec_t;

   localparam int NVEC = 19;
   vec_t vecs [NVEC];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [5:0] c, input logic [2:0] d,
                        input logic [2:0] s1, input logic [2:0] s2,
                        input logic [15:0] im, input logic w);
      bus.instr_valid = v;
      bus.instr_ctrl  = c;
      bus.instr_dr    = d;
      bus.instr_sr1   = s1;
      bus.instr_sr2   = s2;
      bus.instr_imm   = im;
      bus.instr_wb    = w;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            valid ctrl  dr    sr1   sr2   imm       wb    rdy   wbv   en    src1      src2      imm       ctrl
      vecs[0]  = '{1'b1, 6'h01, 3'd3, 3'd0, 3'd0, 16'h1234, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h1234, 6'h01};
      vecs[1]  = '{1'b0, 6'h00, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1234, 6'h01};
      vecs[2]  = '{1'b1, 6'h02, 3'd1, 3'd3, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234, 16'h0000, 16'h0000, 6'h02};
      vecs[3]  = '{1'b1, 6'h03, 3'd6, 3'd3, 3'd3, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h1234, 16'h0000, 6'h03};
      vecs[4]  = '{1'b1, 6'h04, 3'd2, 3'd3, 3'd0, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1, 16'h1234, 16'h0000, 16'h0001, 6'h04};
      vecs[5]  = '{1'b1, 6'h05, 3'd7, 3'd2, 3'd0, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0001, 6'h04};
      vecs[6]  = '{1'b1, 6'h05, 3'd7, 3'd2, 3'd0, 16'h0010, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1235, 16'h0000, 16'h0010, 6'h05};
      vecs[7]  = '{1'b1, 6'h06, 3'd0, 3'd1, 3'd4, 16'h0001, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0001, 6'h06};
      vecs[8]  = '{1'b1, 6'h07, 3'd1, 3'd5, 3'd6, 16'h0002, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'h0002, 6'h07};
      vecs[9]  = '{1'b1, 6'h08, 3'd4, 3'd7, 3'd3, 16'h0003, 1'b1, 1'b1, 1'b1, 1'b1, 16'h1245, 16'h1234, 16'h0003, 6'h08};
      vecs[10] = '{1'b1, 6'h09, 3'd5, 3'd2, 3'd6, 16'h0004, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1235, 16'h0000, 16'h0004, 6'h09};
      vecs[11] = '{1'b1, 6'h0A, 3'd3, 3'd5, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0001, 16'h0000, 6'h0A};
      vecs[12] = '{1'b0, 6'h00, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0000, 6'h0A};
      vecs[13] = '{1'b0, 6'h00, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0000, 6'h0A};
      vecs[14] = '{1'b1, 6'h0B, 3'd0, 3'd5, 3'd4, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h247C, 16'h0000, 6'h0B};
      vecs[15] = '{1'b0, 6'h00, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h247C, 16'h0000, 6'h0B};
      vecs[16] = '{1'b1, 6'h0C, 3'd5, 3'd0, 3'd0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 16'h0001, 16'h0000, 6'h0C};
      vecs[17] = '{1'b1, 6'h0D, 3'd6, 3'd1, 3'd5, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0001, 16'h0001, 16'h0000, 6'h0C};
      vecs[18] = '{1'b1, 6'h0D, 3'd6, 3'd1, 3'd5, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0002, 16'h0002, 16'h0000, 6'h0D};

      // Reset held with a valid instruction pending
      reset = 1'b0;
      drive(1'b1, 6'h3F, 3'd1, 3'd2, 3'd3, 16'hFFFF, 1'b1);
      repeat (3) @(posedge clock);
      #1;
      check("rst_enable_ex", {31'b0, enable_ex}, 32'd0);
      check("rst_src1", {16'b0, src1}, 32'd0);
      check("rst_src2", {16'b0, src2}, 32'd0);
      check("rst_imm", {16'b0, imm}, 32'd0);
      check("rst_control_in", {26'b0, control_in}, 32'd0);
      check("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      drive(1'b0, 6'h00, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0);
      #1;
      check("rst_ready", {31'b0, bus.instr_ready}, 32'd1);
      $display("reset: enable_ex=%0b src1=%h src2=%h ready=%0b", enable_ex, src1, src2, bus.instr_ready);

      for (int i = 0; i < NVEC; i++) begin
         @(negedge clock);
         drive(vecs[i].valid, vecs[i].ctrl, vecs[i].dr, vecs[i].sr1, vecs[i].sr2, vecs[i].immIn, vecs[i].wb);
         #1;
         check($sformatf("ready[%0d]", i), {31'b0, bus.instr_ready}, {31'b0, vecs[i].eReady});
         check($sformatf("wb_valid[%0d]", i), {31'b0, wb_valid}, {31'b0, vecs[i].eWbv});
         @(posedge clock);
         #1;
         check($sformatf("enable_ex[%0d]", i), {31'b0, enable_ex}, {31'b0, vecs[i].eEn});
         check($sformatf("src1[%0d]", i), {16'b0, src1}, {16'b0, vecs[i].eSrc1});
         check($sformatf("src2[%0d]", i), {16'b0, src2}, {16'b0, vecs[i].eSrc2});
         check($sformatf("imm[%0d]", i), {16'b0, imm}, {16'b0, vecs[i].eImm});
         check($sformatf("control_in[%0d]", i), {26'b0, control_in}, {26'b0, vecs[i].eCtrl});
         $display("row %0d: valid=%0b dr=%0d sr1=%0d sr2=%0d ready=%0b en=%0b src1=%h src2=%h imm=%h ctrl=%h wbv=%0b",
                  i, vecs[i].valid, vecs[i].dr, vecs[i].sr1, vecs[i].sr2, bus.instr_ready,
                  enable_ex, src1, src2, imm, control_in, wb_valid);
      end

      // Reset lands in the cycle the dr=4 result would be written back
      @(negedge clock);
      drive(1'b1, 6'h0E, 3'd4, 3'd5, 3'd5, 16'h5555, 1'b1);
      #1;
      check("mid_issue_ready", {31'b0, bus.instr_ready}, 32'd1);
      @(posedge clock);
      #1;
      check("mid_issue_en", {31'b0, enable_ex}, 32'd1);
      @(negedge clock);
      drive(1'b0, 6'h00, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0);
      #1;
      check("mid_ex_wbv", {31'b0, wb_valid}, 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      check("mid_rst_wbv", {31'b0, wb_valid}, 32'd0);
      check("mid_rst_en", {31'b0, enable_ex}, 32'd0);
      check("mid_rst_src1", {16'b0, src1}, 32'd0);
      @(negedge clock);
      check("mid_rst_wbv2", {31'b0, wb_valid}, 32'd0);
      @(posedge clock);
      #1;
      check("mid_rst_wbv3", {31'b0, wb_valid}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      drive(1'b1, 6'h0F, 3'd0, 3'd4, 3'd4, 16'h0000, 1'b0);
      #1;
      check("post_rst_ready", {31'b0, bus.instr_ready}, 32'd1);
      check("post_rst_wbv", {31'b0, wb_valid}, 32'd0);
      @(posedge clock);
      #1;
      check("post_rst_en", {31'b0, enable_ex}, 32'd1);
      check("post_rst_r4_src1", {16'b0, src1}, 32'd0);
      check("post_rst_r4_src2", {16'b0, src2}, 32'd0);
      @(negedge clock);
      drive(1'b0, 6'h00, 3'd0, 3'd0, 3'd0, 16'h0000, 1'b0);
      #1;
      check("post_rst_wbv2", {31'b0, wb_valid}, 32'd0);
      $display("mid-flight reset: r4 read src1=%h src2=%h wbv=%0b", src1, src2, wb_valid);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/execute_issue_stage.md
Name: execute_issue_stage

Overview:
- Upstream partner of the Execute stage. Accepts decoded instructions over a valid/ready handshake.
- Owns the 8-entry architectural register file and reads operands from it.
- Drives src1/src2/imm/control_in/enable_ex into Execute.
- Writes aluout back into the register file.
- Inserts one bubble on a read-after-write hazard against the instruction currently in Execute.

Parameters:
DATA_W, 16, width of operands, imm and aluout
CTRL_W, 6, width of control_in word passed to Execute
NREGS, 8, register-file entries (register index width RIDX_W = clog2(NREGS))

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low; clears all state
instr_valid  input  1  upstream instruction present
instr_ready  output  1  stage can accept this cycle
instr_ctrl  input  CTRL_W  control word forwarded to Execute
instr_dr  input  RIDX_W  destination register
instr_sr1  input  RIDX_W  source register 1
instr_sr2  input  RIDX_W  source register 2
instr_imm  input  DATA_W  sign-extended immediate
instr_wb  input  1  instruction writes instr_dr
src1  output  DATA_W  operand 1 to Execute
src2  output  DATA_W  operand 2 to Execute
imm  output  DATA_W  immediate to Execute
control_in  output  CTRL_W  control to Execute
enable_ex  output  1  Execute consumes operands this cycle
aluout  input  DATA_W  Execute result, valid cycle after enable_ex
wb_valid  output  1  register-file write occurring this cycle (observability)

Behaviour:
- Reset (reset==0, async): src1, src2, imm, control_in = 0; enable_ex = 0; wb_valid = 0; all registers = 0; pipeline valid flags = 0. instr_ready = 1 after reset deasserts.
- Accept = instr_valid & instr_ready, sampled at rising edge.
- Cycle N, accept:
  - sr1/sr2 are read combinationally.
  - At the edge ending N, register src1, src2, imm = instr_imm, control_in = instr_ctrl, enable_ex = 1, ex_dr = instr_dr, ex_wb = instr_wb.
- Cycle N+1: EX stage holds the instruction.
- Cycle N+2: aluout is valid.
  - If ex_wb was set, the stage writes aluout to reg[ex_dr] at the edge ending N+2, with wb_valid = 1 during N+2.
  - Writeback bypass: in N+2, a read of ex_dr returns aluout, not the stale register.
- No accept in a cycle -> enable_ex = 0 next cycle. src1, src2, imm, control_in hold their last values.
- Hazard:
  - instr_ready = 0 when the EX stage is valid, ex_wb = 1, and (instr_sr1 == ex_dr or instr_sr2 == ex_dr).
  - Otherwise instr_ready = 1.
  - Exactly one bubble: the next cycle the instruction is at writeback, where bypass covers it.
- Register 0 is an ordinary register (no hardwired zero).
- Writeback and a new accept in the same cycle are both legal. A same-register read gets the bypassed value.
- Back-to-back independent instructions: one issue per cycle, enable_ex held high.
- instr_valid with instr_ready = 0: upstream must hold all fields stable. The stage takes no action until ready rises.
- Reset mid-operation: in-flight EX/WB instructions are discarded and no writeback occurs.
- Arithmetic: none in this block; widths pass through unmodified.

Decomposition:
- Package execute_pkg holds:
  - DATA_W, CTRL_W, NREGS, RIDX_W constants.
  - typedef struct issue_instr_t {ctrl, dr, sr1, sr2, imm, wb}.
  - typedef struct ex_tag_t {valid, dr, wb}.
- Sub-module issue_regfile: NREGS x DATA_W, two combinational read ports with writeback bypass, one write port, async active-low clear.
- Hazard logic and EX/WB tag pipeline stay in the top.

Test Plan:
- Reset: hold reset=0 for 3 cycles with instr_valid=1 -> enable_ex=0, src1=src2=imm=0, instr_ready=1 after release, wb_valid=0.
- Single writeback: issue ctrl=ADD, dr=3, sr1=0, sr2=0, wb=1, with the Execute model returning aluout=16'h1234 -> wb_valid=1 two cycles after accept. A later read of r3 drives src1=16'h1234.
- Hazard bubble: issue dr=2 (wb=1), then sr1=2 on the next cycle -> instr_ready=0 for exactly 1 cycle and enable_ex pattern 1,0,1. The second src1 equals the first aluout via bypass.
- Independent back-to-back: 4 instructions with disjoint registers -> instr_ready stays 1 and enable_ex = 1 for 4 consecutive cycles.
- No-writeback hazard exemption: instr_wb=0 on dr=5, next sr1=5 -> no stall, wb_valid stays 0, r5 unchanged.
- Reset mid-flight: pulse reset low in the cycle aluout is valid for dr=4 -> r4 reads 0 afterwards, wb_valid never asserted.
